dff_ram_param: RTL
==================

# dff_ram_param

Parametrised flip-flop RAM, the successor to the fixed 72-bit by 8-word DFF RAM. It adds width and depth parameters, per-byte write masking, a registered read with a valid strobe, and a hardware clear sweep that zeroes the array after reset or on request. It sits beside the datapath as a small single-port scratch store, using the same active-low `en`/`wr` command convention as its predecessor.

## Interface
- `WIDTH`, 72: data width in bits; must be a multiple of 8.
- `DEPTH`, 8: number of words; 2 to 2**`ADDR_W`.
- `ADDR_W`, 3: address width in bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: active-low access enable.
- `wr` in 1: active-low write select; `wr`=1 with `en`=0 is a read.
- `be` in `WIDTH/8`: active-high byte-write mask; bit i covers `data_in[8i+7:8i]`.
- `address` in `ADDR_W`: word address.
- `data_in` in `WIDTH`: write data.
- `clr` in 1: active-high request to start a clear sweep; sampled only in IDLE.
- `data_out` out `WIDTH`: registered read data.
- `rd_valid` out 1: one-cycle pulse, aligned with new `data_out`.
- `busy` out 1: high while a clear sweep is running; accesses are ignored while it is high.
- `par_err` out 1: read parity error, aligned with `rd_valid`.

## Operation
- **Storage**
  - The array consists of `DEPTH` x `WIDTH` flops with no reset.
  - The array is initialised only by the clear sweep.
- **State machine** (states CLEAR, IDLE)
  - While `rst` is asserted: state=CLEAR and `clr_ptr`=0.
  - CLEAR:
    - Each cycle, write zero (and zero parity) to `clr_ptr`, then increment `clr_ptr`.
    - At `clr_ptr`=`DEPTH`-1, write that word and go to IDLE.
  - IDLE:
    - `clr`=1 goes to CLEAR with `clr_ptr`=0.
    - `clr` has priority over an access presented in the same cycle; that access is dropped.
- **Access rules** (IDLE, `clr`=0)
  - **Write** (`en`=0, `wr`=0):
    - At the edge, each byte with `be[i]`=1 is updated; bytes with `be[i]`=0 are unchanged.
    - `be`=0 is a legal no-op.
    - `data_out` and `rd_valid` are unaffected.
  - **Read** (`en`=0, `wr`=1):
    - `data_out` is loaded with the word at `address`.
    - `rd_valid` is set to 1 for exactly one cycle.
  - **No access** (`en`=1):
    - `data_out` holds its last value.
    - `rd_valid`=0.
- **Out-of-range address** (`address` >= `DEPTH`)
  - A write is ignored.
  - A read returns all zeros with `rd_valid`=1 and `par_err`=0.
- **Busy**
  - While `busy`=1, `en`, `wr` and `clr` are ignored.
  - No `rd_valid` is produced.
- **Reset mid-sweep**: the sweep restarts from 0.
- **`clr` during CLEAR**: ignored; it does not extend the sweep.

## Timing
- **Reset values**:
  - `data_out`=0
  - `rd_valid`=0
  - `par_err`=0
  - `busy`=1
  - state=CLEAR
- **Clear duration**:
  - Exactly `DEPTH` rising edges after `rst` deasserts (or after the edge that sampled `clr`).
  - `busy` falls after the `DEPTH`th edge.
  - The first access is accepted on the following edge.
- **`busy` during a `clr`-started sweep**: rises on the edge after `clr` is sampled and is a registered output.
- **Read latency**: 1 cycle. Inputs are sampled at edge N; `data_out`/`rd_valid`/`par_err` are valid after edge N.
- **Write timing**: visible to a read sampled on the next edge. Back-to-back write then read of the same address returns the new data.
- **Throughput**: one access per cycle in IDLE.

## Configuration
- Macro: `DFF_RAM_PARITY_EN`.
- **Defined**:
  - Each byte stores an extra even-parity bit, computed from the byte written.
  - Parity bits are written only for bytes with `be[i]`=1.
  - On an in-range read, `par_err` is set to 1 if any stored byte parity mismatches; it is registered with `rd_valid`.
  - The clear sweep writes parity 0.
- **Undefined**:
  - No parity flops exist.
  - `par_err` is tied to 0.

## Test plan
- **Reset and clear**:
  - Stimulus: hold `rst`=1 for 3 cycles, release; with `DEPTH`=8, read all addresses after `busy` falls.
  - Required: `busy`=1 for exactly 8 edges, then 0; all reads return 0 with `rd_valid` pulses and `par_err`=0.
- **Full and byte-masked write**:
  - Stimulus: write `72'h123456789ABCDEF012` to address 4 with all `be` set; then write `72'hFFFFFFFFFFFFFFFFFF` to address 4 with `be`=9'h001; read address 4.
  - Required: read returns `72'h123456789ABCDEF0FF` one cycle after the read command.
- **Back-to-back accesses**:
  - Stimulus: write `72'h89ABCDEF0121234567` to address 3; next cycle read 3; next cycle read 4.
  - Required: consecutive `rd_valid` pulses returning `...4567`, then the address-4 data.
- **Out-of-range and busy**:
  - Stimulus: `DEPTH`=6; write to address 7; read address 7; then assert `clr` together with a read.
  - Required:
    - The address-7 write is ignored, and the read returns 0 with `rd_valid`=1.
    - The read issued with `clr` produces no `rd_valid`.
    - `busy` is high for 6 cycles, and every word reads 0 afterward.
- **Reset mid-sweep**:
  - Stimulus: assert `clr`, then pulse `rst` after 3 sweep cycles.
  - Required: `busy` stays high; the sweep restarts at 0 and lasts the full `DEPTH` cycles after `rst` falls.
- **Parity (with `DEPTH`=8 and `DFF_RAM_PARITY_EN`)**:
  - Stimulus: use `$deposit`/`force` to flip one stored data bit of address 2, then read address 2.
  - Required: `par_err`=1 with `rd_valid`; reading an untouched address gives `par_err`=0.

Source files
------------

// File: rtl/dff_ram_param.sv
// rtl/dff_ram_param.sv - parametrised single-port flop RAM with byte mask, registered read, clear sweep; optional parity under DFF_RAM_PARITY_EN
module dff_ram_param #(
    parameter int WIDTH  = 72,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr,
    input  logic [WIDTH/8-1:0]   be,
    input  logic [ADDR_W-1:0]    address,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 clr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 par_err
);

    localparam int                NB       = WIDTH / 8;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;

    // Storage has no reset; the clear sweep is the only initialisation.
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               par_err_q, par_err_d;

    logic               in_range;
    logic               accept;
    logic               wr_fire;
    logic               rd_fire;
    logic               rd_par_mismatch;

    // clr wins over a same-cycle access, and nothing is accepted mid-sweep.
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign accept   = (state_q == S_IDLE) && !clr;
    assign wr_fire  = accept && !en && !wr && in_range;
    assign rd_fire  = accept && !en && wr;

    // State and sweep pointer register; reset restarts the sweep from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: sweep one word per cycle, return to IDLE after the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = S_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (clr) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Array write: sweep zeroes one word, otherwise masked byte writes.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem_q[address][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

`ifdef DFF_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];

    // Parity write: even parity per written byte, zero during the sweep.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            par_q[clr_ptr_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par_q[address][i] <= ^data_in[8*i +: 8];
                end
            end
        end
    end

    // Parity check of the addressed word; only consumed for in-range reads.
    always_comb begin
        rd_par_mismatch = 1'b0;
        if (in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (par_q[address][i] != (^mem_q[address][8*i +: 8])) begin
                    rd_par_mismatch = 1'b1;
                end
            end
        end
    end
`else
    assign rd_par_mismatch = 1'b0;
`endif

    // Read next-state: load on a read, hold data otherwise, pulse valid.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        par_err_d  = 1'b0;
        if (rd_fire) begin
            rd_valid_d = 1'b1;
            if (in_range) begin
                data_out_d = mem_q[address];
                par_err_d  = rd_par_mismatch;
            end else begin
                data_out_d = '0;
            end
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            par_err_q  <= par_err_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign par_err  = par_err_q;
    assign busy     = (state_q == S_CLEAR);

endmodule
